multicycle_controller: RTL and testbench

- Moore-style control FSM that sequences `multicycle_computer_datapath_verilog`.
- Decodes the latched instruction (INSTRUCTION_OUT) and condition flags (FLAGS), then drives every datapath control strobe cycle by cycle.
- Replaces hand-driven control vectors in benches; sits beside the datapath inside the top-level computer.

---
 rtl/multicycle_pkg.sv | 78 +++++++
 rtl/cond_check.sv | 32 +++
 rtl/multicycle_controller.sv | 166 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction fields and datapath select codes.
package multicycle_pkg;

    localparam int unsigned NUM_STATES = 11;
    localparam int unsigned STATE_W    = $clog2(NUM_STATES);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = STATE_W'(0),
        S_FETCH    = STATE_W'(1),
        S_DECODE   = STATE_W'(2),
        S_MEMADR   = STATE_W'(3),
        S_MEMREAD  = STATE_W'(4),
        S_MEMWB    = STATE_W'(5),
        S_MEMWRITE = STATE_W'(6),
        S_EXECR    = STATE_W'(7),
        S_EXECI    = STATE_W'(8),
        S_ALUWB    = STATE_W'(9),
        S_BRANCH   = STATE_W'(10)
    } state_e;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RD1   = 2'b01;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b11;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] REGSRC_RR  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_DEF = 2'b10;
    localparam logic [2:0] SHIFT_NONE = 3'b111;

    function automatic logic [2:0] alu_op_of(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: alu_op_of = ALU_SUB;
            CMD_AND:          alu_op_of = ALU_AND;
            CMD_ORR:          alu_op_of = ALU_ORR;
            CMD_MOV:          alu_op_of = ALU_MOV;
            default:          alu_op_of = ALU_ADD;
        endcase
    endfunction

    // Commands whose result is written back to the register file.
    function automatic logic cmd_writes(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV: cmd_writes = 1'b1;
            default:                                     cmd_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluator: decides whether an instruction executes given its cond field and {N,Z,C,V}.
module cond_check
    import multicycle_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_c_o
);

    logic flag_n, flag_z, flag_v;
    logic unused_carry;

    assign flag_n       = flags_i[3];
    assign flag_z       = flags_i[2];
    assign unused_carry = flags_i[1];
    assign flag_v       = flags_i[0];

    always_comb begin
        cond_ex_c_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_c_o = flag_z;
            COND_NE: cond_ex_c_o = !flag_z;
            COND_GE: cond_ex_c_o = (flag_n == flag_v);
            COND_LT: cond_ex_c_o = (flag_n != flag_v);
            COND_GT: cond_ex_c_o = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ex_c_o = flag_z || (flag_n != flag_v);
            COND_AL: cond_ex_c_o = 1'b1;
            default: cond_ex_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the multicycle datapath; outputs decode from the state register and latched instruction.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_out,
    output logic        instr_done
);

    state_e state_q, state_d;

    logic [3:0] cond_f;
    logic [1:0] op_f;
    logic       imm_f;
    logic [3:0] cmd_f;
    logic       sl_f;
    logic       link_f;
    logic       is_cmp;
    logic       dp_ends;
    logic       cond_ex_c;
    logic       unused_instr;

    assign cond_f       = INSTRUCTION_OUT[31:28];
    assign op_f         = INSTRUCTION_OUT[27:26];
    assign imm_f        = INSTRUCTION_OUT[25];
    assign cmd_f        = INSTRUCTION_OUT[24:21];
    assign sl_f         = INSTRUCTION_OUT[20];
    assign link_f       = INSTRUCTION_OUT[24];
    assign unused_instr = ^INSTRUCTION_OUT[19:0];

    // CMP and unsupported commands have nothing to write back.
    assign is_cmp  = (cmd_f == CMD_CMP);
    assign dp_ends = is_cmp || !cmd_writes(cmd_f);

    cond_check u_cond_check (
        .cond_i      (cond_f),
        .flags_i     (FLAGS),
        .cond_ex_c_o (cond_ex_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign state_out = 4'(state_q);

    always_comb begin
        state_d    = state_q;
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        RegSrc     = REGSRC_DEF;
        ALUop      = ALU_ADD;
        ShiftType  = SHIFT_NONE;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (!cond_ex_c || op_f == OP_UNDEF) begin
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end else if (op_f == OP_MEM) begin
                    state_d = S_MEMADR;
                end else if (op_f == OP_DP) begin
                    state_d = imm_f ? S_EXECI : S_EXECR;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = sl_f ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                AdrSrc     = 1'b1;
                RegWrite   = 1'b1;
                ResultSrc  = RES_DATA;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                RegSrc     = (state_q == S_EXECI) ? REGSRC_DEF : REGSRC_RR;
                ALUop      = alu_op_of(cmd_f);
                FlagUpdate = sl_f || is_cmp;
                instr_done = dp_ends;
                state_d    = dp_ends ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                ResultSrc  = RES_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURES;
                PCWrite    = 1'b1;
                RegSrc     = REGSRC_BR;
                RegWrite   = link_f;
                A3Src      = link_f;
                WD3Src     = link_f;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions plus random ones against a path/table model.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  state_out;
    logic        instr_done;

    int errors = 0;
    int checks = 0;
    int path[$];

    multicycle_controller dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .INSTRUCTION_OUT (instr),
        .FLAGS           (flags),
        .A3Src           (A3Src),
        .AdrSrc          (AdrSrc),
        .FlagUpdate      (FlagUpdate),
        .IRWrite         (IRWrite),
        .MemWrite        (MemWrite),
        .PCWrite         (PCWrite),
        .RegWrite        (RegWrite),
        .WD3Src          (WD3Src),
        .ALUSrcA         (ALUSrcA),
        .ALUSrcB         (ALUSrcB),
        .ResultSrc       (ResultSrc),
        .RegSrc          (RegSrc),
        .ALUop           (ALUop),
        .ShiftType       (ShiftType),
        .state_out       (state_out),
        .instr_done      (instr_done)
    );

    always #5 clock = ~clock;

    // {state, done, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
    //  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType}
    logic [26:0] obs;
    assign obs = {state_out, instr_done, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite,
                  RegWrite, WD3Src, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType};

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit writes_back(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b1101;
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b1010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b1101: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Expected strobes/selects for a given state number, straight from the per-state output table.
    function automatic logic [21:0] exp_ctl(input int st, input logic [31:0] ins);
        logic a3, adr, fu, irw, mw, pcw, rw, wd3;
        logic [1:0] sa, sb, rs, rg;
        logic [2:0] alu;
        {a3, adr, fu, irw, mw, pcw, rw, wd3} = 8'b0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; rg = 2'b10; alu = 3'b000;
        case (st)
            1:  begin irw = 1; pcw = 1; sb = 2'b11; rs = 2'b10; end
            2:  begin sb = 2'b11; rs = 2'b10; end
            3:  begin sa = 2'b01; sb = 2'b01; end
            4:  begin sa = 2'b01; sb = 2'b01; adr = 1; end
            5:  begin adr = 1; rw = 1; rs = 2'b01; end
            6:  begin adr = 1; mw = 1; sa = 2'b01; sb = 2'b01; end
            7, 8: begin
                sa  = 2'b01;
                sb  = (st == 8) ? 2'b01 : 2'b00;
                rg  = (st == 8) ? 2'b10 : 2'b00;
                alu = alu_code(ins[24:21]);
                fu  = ins[20] || (ins[24:21] == 4'b1010);
            end
            9:  begin rw = 1; rs = 2'b00; end
            10: begin
                sa = 2'b00; sb = 2'b01; rs = 2'b10; pcw = 1; rg = 2'b01;
                if (ins[24]) begin rw = 1; a3 = 1; wd3 = 1; end
            end
            default: ;
        endcase
        return {a3, adr, fu, irw, mw, pcw, rw, wd3, sa, sb, rs, rg, alu, 3'b111};
    endfunction

    // Sequence of state numbers an instruction visits, starting at FETCH.
    task automatic build_path(input logic [31:0] ins, input logic [3:0] f);
        logic [1:0] op;
        op = ins[27:26];
        path.delete();
        path.push_back(1);
        path.push_back(2);
        if (cond_pass(ins[31:28], f) && op != 2'b11) begin
            if (op == 2'b01) begin
                path.push_back(3);
                if (ins[20]) begin path.push_back(4); path.push_back(5); end
                else path.push_back(6);
            end else if (op == 2'b00) begin
                path.push_back(ins[25] ? 8 : 7);
                if (writes_back(ins[24:21])) path.push_back(9);
            end else begin
                path.push_back(10);
            end
        end
    endtask

    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered one time unit after the edge into FETCH; leaves one unit after the edge back into FETCH.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] f);
        instr = ins;
        flags = f;
        build_path(ins, f);
        for (int i = 0; i < path.size(); i++) begin
            @(negedge clock);
            check(tag, obs, {4'(path[i]), (i == path.size() - 1), exp_ctl(path[i], ins)});
            @(posedge clock);
            #1;
        end
    endtask

    logic [26:0] idle_vec;
    logic [3:0]  cmds [6];
    logic [31:0] rins;

    initial begin
        idle_vec = {4'd0, 1'b0, exp_ctl(0, 32'h0)};
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101};
        reset = 1'b0;
        run   = 1'b0;
        instr = 32'h0;
        flags = 4'h0;
        #2;
        check("reset_idle", obs, idle_vec);

        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("idle_hold", obs, idle_vec);
        end
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;

        run_instr("ldr",       32'hE5900040, 4'b0000);
        run_instr("str",       32'hE5810041, 4'b0000);
        run_instr("adds",      32'hE0902001, 4'b0000);
        run_instr("cmp_imm",   32'hE3500005, 4'b0000);
        run_instr("beq_taken", 32'h0A000002, 4'b0100);
        run_instr("beq_fail",  32'h0A000002, 4'b0000);
        run_instr("bl",        32'hEB000002, 4'b0000);
        run_instr("undef",     32'hEC000000, 4'b1111);

        for (int n = 0; n < 150; n++) begin
            rins = $urandom;
            if ($urandom_range(0, 1) == 1) rins[31:28] = 4'hE;
            if (rins[27:26] == 2'b00 && $urandom_range(0, 3) != 0) rins[24:21] = cmds[$urandom_range(0, 5)];
            run_instr("random", rins, 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset in the middle of a load.
        instr = 32'hE5900040;
        flags = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        check("pre_reset_memread", obs, {4'd4, 1'b0, exp_ctl(4, instr)});
        reset = 1'b0;
        #1;
        check("async_reset", obs, idle_vec);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("idle_after_reset", obs, idle_vec);
        end
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
        run_instr("ldr_after_reset", 32'hE5900040, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
